// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared FSM state and operation encodings for the SDRAM port arbiter
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} arb_state_t;
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after a pointer
module rr_arbiter #(
  parameter int NUM_CH = 2,
  localparam int IDX_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_valid
);
  logic [IDX_W-1:0] w_c;
  // Scan from the farthest offset down so the nearest requester after the pointer wins
  always_comb begin
    o_idx = '0;
    w_c = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_c = IDX_W'((int'(i_ptr) + k) % NUM_CH);
      if (i_req[w_c]) o_idx = w_c;
    end
    o_valid = |i_req;
    o_grant = o_valid ? NUM_CH'(1) << o_idx : '0;
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin multi-channel front end for one SDRAM slave port (watchdog via SDRAM_ARB_TIMEOUT_EN)
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*BE_W-1:0]   ch_byte_enable,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*DATA_W-1:0] ch_write_data,
  output logic [NUM_CH-1:0]        ch_acknowledge,
  output logic [DATA_W-1:0]        ch_read_data,
  output logic [ADDR_W-1:0]        sdram_address,
  output logic [BE_W-1:0]          sdram_byte_enable,
  output logic                     sdram_read,
  output logic                     sdram_write,
  output logic [DATA_W-1:0]        sdram_write_data,
  input  logic                     sdram_acknowledge,
  input  logic [DATA_W-1:0]        sdram_read_data,
  output logic                     timeout_err
);
  localparam int IDX_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  if (NUM_CH < 1 || NUM_CH > 8 || DATA_W % 8 != 0 || ADDR_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("sdram_port_arbiter: invalid parameter set");
  end
  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_idx;
  logic [NUM_CH-1:0]   r_oh;
  logic                r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_sd_rd;
  logic                r_sd_wr;
  logic [NUM_CH-1:0]   r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic [NUM_CH-1:0]   w_req;
  logic [NUM_CH-1:0]   w_grant;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic                w_op;
`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1) > 8 ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_terr;
  assign timeout_err = r_terr;
`else
  assign timeout_err = 1'b0;
`endif
  assign w_req = ch_read | ch_write;
  // Write wins when a channel raises read and write together
  assign w_op  = ch_write[w_idx] ? OP_WRITE : OP_READ;
  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .i_req  (w_req),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_valid(w_any)
  );
  // Transaction FSM: grant and capture in IDLE, hold the SDRAM op in ISSUE, ack the client in DONE
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_oh    <= '0;
      r_op    <= OP_READ;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_sd_rd <= 1'b0;
      r_sd_wr <= 1'b0;
      r_ack   <= '0;
      r_rdata <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_terr  <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      r_terr <= 1'b0;
`endif
      case (r_state)
        IDLE: if (w_any) begin
          r_idx   <= w_idx;
          r_oh    <= w_grant;
          r_op    <= w_op;
          r_addr  <= ch_address[w_idx*ADDR_W +: ADDR_W];
          r_be    <= ch_byte_enable[w_idx*BE_W +: BE_W];
          r_wdata <= ch_write_data[w_idx*DATA_W +: DATA_W];
          r_sd_rd <= w_op == OP_READ;
          r_sd_wr <= w_op == OP_WRITE;
`ifdef SDRAM_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_state <= ISSUE;
        end
        ISSUE: if (sdram_acknowledge) begin
          r_sd_rd <= 1'b0;
          r_sd_wr <= 1'b0;
          r_ack   <= r_oh;
          r_rdata <= r_op == OP_WRITE ? '0 : sdram_read_data;
          r_state <= DONE;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          r_sd_rd <= 1'b0;
          r_sd_wr <= 1'b0;
          r_ack   <= r_oh;
          r_rdata <= '1;
          r_terr  <= 1'b1;
          r_state <= DONE;
        end else r_cnt <= r_cnt + 1'b1;
`endif
        DONE: begin
          r_ptr   <= r_idx == IDX_W'(NUM_CH - 1) ? '0 : r_idx + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign ch_acknowledge    = r_ack;
  assign ch_read_data      = r_rdata;
  assign sdram_address     = r_addr;
  assign sdram_byte_enable = r_be;
  assign sdram_read        = r_sd_rd;
  assign sdram_write       = r_sd_wr;
  assign sdram_write_data  = r_wdata;
endmodule
